// File: rtl/scpu_data_mem.sv
// scpu_data_mem: data-memory responder for the SCPU load/store port.
// A request is accepted in IDLE and latched, then WAIT_CYCLES wait states
// pass, then a one-cycle RESP asserts Ready (and AddrErr on a bad request).
// Optional macro SCPU_DMEM_BYTE_EN_EN adds a ByteEn[3:0] write-mask input.
module scpu_data_mem #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
`ifdef SCPU_DMEM_BYTE_EN_EN
  input  logic [3:0]  ByteEn,
`endif
  output logic [31:0] RdData,
  output logic        Ready,
  output logic        AddrErr,
  output logic        Busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  // Last wait-state count; only meaningful when WAIT_CYCLES > 0.
  localparam logic [3:0] WLAST  = 4'(WAIT_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0]           wdata_q;
  logic                  rd_q, wr_q, err_q;
  logic [31:0]           rdata_q;
  logic [3:0]            be_q;
  logic [3:0]            be_in;
  logic                  req, accept, req_err;

  logic [31:0] mem_q [2**DEPTH_LOG2];

`ifdef SCPU_DMEM_BYTE_EN_EN
  assign be_in = ByteEn;
`else
  assign be_in = 4'hF;
`endif

  assign req    = MemRead | MemWr;
  assign accept = (state_q == S_IDLE) && req;

  // Error is judged on the request as it is accepted and then carried along.
  always_comb begin
    req_err = 1'b0;
    if (Addr[1:0] != 2'b00)                  req_err = 1'b1;
    if ((Addr >> (DEPTH_LOG2 + 2)) != 32'd0) req_err = 1'b1;
    if (MemRead && MemWr)                    req_err = 1'b1;
    if (MemWr && !MemRead && be_in == 4'h0)  req_err = 1'b1;
  end

  // Next-state and wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req) begin
        cnt_d   = 4'd0;
        state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (cnt_q == WLAST) state_d = S_RESP;
        else                cnt_d   = cnt_q + 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch the request at acceptance; ignored until the next IDLE.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      be_q    <= 4'h0;
    end else if (accept) begin
      idx_q   <= Addr[DEPTH_LOG2+1:2];
      wdata_q <= WrData;
      rd_q    <= MemRead;
      wr_q    <= MemWr;
      err_q   <= req_err;
      be_q    <= be_in;
    end
  end

  // Read data is shown combinationally in RESP and held afterwards.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) rdata_q <= 32'd0;
    else        rdata_q <= RdData;
  end

  // Write commit on the RESP edge; array contents survive reset.
  always_ff @(posedge CLK) begin
    if (state_q == S_RESP && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
    end
  end

  assign RdData  = (state_q == S_RESP && rd_q && !err_q) ? mem_q[idx_q] : rdata_q;
  assign Ready   = (state_q == S_RESP);
  assign AddrErr = (state_q == S_RESP) && err_q;
  assign Busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_scpu_data_mem.sv
// Directed bench: two responders, WAIT_CYCLES=0 (index 0) and 1 (index 1).
module tb_scpu_data_mem;

  logic        CLK = 1'b0;
  logic        rstn  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [3:0]  be    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];
  logic        busy  [2];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  scpu_data_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_w0 (
    .CLK(CLK), .reset(rstn[0]), .MemRead(rd[0]), .MemWr(wr[0]),
    .Addr(addr[0]), .WrData(wd[0]),
`ifdef SCPU_DMEM_BYTE_EN_EN
    .ByteEn(be[0]),
`endif
    .RdData(rdata[0]), .Ready(rdy[0]), .AddrErr(err[0]), .Busy(busy[0]));

  scpu_data_mem #(.DEPTH_LOG2(8), .WAIT_CYCLES(1)) u_w1 (
    .CLK(CLK), .reset(rstn[1]), .MemRead(rd[1]), .MemWr(wr[1]),
    .Addr(addr[1]), .WrData(wd[1]),
`ifdef SCPU_DMEM_BYTE_EN_EN
    .ByteEn(be[1]),
`endif
    .RdData(rdata[1]), .Ready(rdy[1]), .AddrErr(err[1]), .Busy(busy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on responder d; returns data/error seen in the Ready cycle
  // and the cycle (1 = cycle after the accepting edge) in which Ready came.
  task automatic xfer(input int d, input logic r, input logic w,
                      input logic [31:0] a, input logic [31:0] wdv, input logic [3:0] bev,
                      output logic [31:0] rdv, output logic e, output int lat);
    @(negedge CLK);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdv; be[d] = bev;
    @(posedge CLK);
    lat = 1;
    @(negedge CLK);
    while (!rdy[d] && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    rdv = rdata[d];
    e   = err[d];
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (lat >= 20) chk("ready_timeout", 32'(lat), 32'd0);
    @(negedge CLK);
    chk("ready_one_cycle", {31'd0, rdy[d]}, 32'd0);
  endtask

  logic [31:0] rv;
  logic        ev;
  int          lt;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; rd[i] = 1'b0; wr[i] = 1'b0;
      addr[i] = 32'd0; wd[i] = 32'd0; be[i] = 4'hF;
    end
    repeat (2) @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk("rst_rdata", rdata[i], 32'd0);
      chk("rst_ready", {31'd0, rdy[i]}, 32'd0);
      chk("rst_err",   {31'd0, err[i]}, 32'd0);
      chk("rst_busy",  {31'd0, busy[i]}, 32'd0);
    end
    rstn[0] = 1'b1; rstn[1] = 1'b1;

    // WAIT_CYCLES=1: write then read back
    xfer(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rv, ev, lt);
    chk("w1_wr_lat", 32'(lt), 32'd2);
    chk("w1_wr_err", {31'd0, ev}, 32'd0);
    xfer(1, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, rv, ev, lt);
    chk("w1_rd_lat", 32'(lt), 32'd2);
    chk("w1_rd_data", rv, 32'hDEADBEEF);

    // WAIT_CYCLES=0: write then read back
    xfer(0, 1'b0, 1'b1, 32'h0, 32'h1, 4'hF, rv, ev, lt);
    chk("w0_wr_lat", 32'(lt), 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rv, ev, lt);
    chk("w0_rd_lat", 32'(lt), 32'd1);
    chk("w0_rd_data", rv, 32'h1);

    // Misaligned and out-of-range reads: error, RdData unchanged
    xfer(0, 1'b1, 1'b0, 32'h13, 32'h0, 4'hF, rv, ev, lt);
    chk("misalign_err", {31'd0, ev}, 32'd1);
    chk("misalign_data", rv, 32'h1);
    xfer(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF, rv, ev, lt);
    chk("range_err", {31'd0, ev}, 32'd1);
    chk("range_data", rv, 32'h1);

    // Read+write conflict leaves the word untouched
    xfer(0, 1'b0, 1'b1, 32'h20, 32'h77, 4'hF, rv, ev, lt);
    chk("pre_conf_err", {31'd0, ev}, 32'd0);
    xfer(0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF, rv, ev, lt);
    chk("conf_err", {31'd0, ev}, 32'd1);
    chk("conf_data", rv, 32'h1);
    xfer(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF, rv, ev, lt);
    chk("conf_readback", rv, 32'h77);
    // Out-of-range write must not alias onto word 0
    xfer(0, 1'b0, 1'b1, 32'h400, 32'hBAD, 4'hF, rv, ev, lt);
    chk("range_wr_err", {31'd0, ev}, 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF, rv, ev, lt);
    chk("range_wr_noalias", rv, 32'h1);

    // Reset mid-WAIT abandons the write
    xfer(1, 1'b0, 1'b1, 32'h40, 32'hAAAA5555, 4'hF, rv, ev, lt);
    xfer(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, rv, ev, lt);
    chk("pre_rst_data", rv, 32'hAAAA5555);
    @(negedge CLK);
    wr[1] = 1'b1; addr[1] = 32'h40; wd[1] = 32'h12345678;
    @(posedge CLK);
    #1;
    chk("acc_busy", {31'd0, busy[1]}, 32'd1);
    chk("acc_ready", {31'd0, rdy[1]}, 32'd0);
    #1;
    rstn[1] = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, rdy[1]}, 32'd0);
    chk("mid_rst_err",   {31'd0, err[1]}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy[1]}, 32'd0);
    chk("mid_rst_rdata", rdata[1], 32'd0);
    wr[1] = 1'b0;
    repeat (2) @(negedge CLK);
    rstn[1] = 1'b1;
    xfer(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF, rv, ev, lt);
    chk("post_rst_data", rv, 32'hAAAA5555);

`ifdef SCPU_DMEM_BYTE_EN_EN
    xfer(0, 1'b0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, rv, ev, lt);
    xfer(0, 1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101, rv, ev, lt);
    chk("be_wr_err", {31'd0, ev}, 32'd0);
    xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, rv, ev, lt);
    chk("be_data", rv, 32'hFF22FF44);
    xfer(0, 1'b0, 1'b1, 32'h8, 32'h0, 4'h0, rv, ev, lt);
    chk("be_zero_err", {31'd0, ev}, 32'd1);
    xfer(0, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rv, ev, lt);
    chk("be_zero_data", rv, 32'hFF22FF44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
